dut_ram: RTL and testbench
==========================

# dut_ram

Single-port synchronous RAM: 64 words × 16 bits, with one write/read address and a registered read output. Used as a small scratch or coefficient store addressed by a controller that writes words and reads them back later. Synchronous reset clears the whole array and the output register in one cycle.

## Interface
- No parameters. Depth is fixed at 64 words and width at 16 bits.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-high. The port keeps the codebase name `rst_n`, but it is asserted when 1. It is sampled only on the `clk` rising edge.
- `we` input 1: write enable, active-high.
- `addr` input 6: word address, 0–63. All 64 locations are valid.
- `data` input 16: write data.
- `out` output 16: registered read data.

## Operation
- Storage: 64 × 16-bit registers, `mem[0..63]`.
- Reset (`rst_n`=1 at a rising edge):
  - every `mem[i]` becomes 16'h0000;
  - `out` becomes 16'h0000;
  - `we`, `addr` and `data` are ignored.
- Write (`rst_n`=0, `we`=1 at a rising edge): `mem[addr]` is loaded with `data`. Other locations are unchanged.
- Read happens on every non-reset rising edge, regardless of `we`:
  - `out` is loaded with the contents of `mem[addr]`;
  - if a write to the same address occurs on that edge, `out` is loaded with the new `data` (write-first).
- `out` holds its value between edges. It has no combinational path from the inputs.
- Address decoding is full: no wrap-around and no out-of-range case.
- X/Z on `addr` while `we`=1 is illegal stimulus. Behaviour in that case is unspecified.

## Timing
- Read latency is 1 cycle. If `addr` is A before rising edge N, then `out` equals `mem[A]` after edge N and stays valid until edge N+1.
- Write latency is 1 cycle. Data written at edge N can be read by presenting the same address before edge N+1, and appears on `out` after edge N+1.
- Read-during-write to the same address at edge N: `out` equals the written `data` after edge N.
- Reset latency is 1 cycle. After the first edge with `rst_n`=1, all words and `out` are 0.
- Reset asserted in the middle of a write sequence: the write on the reset edge is discarded, and all previously written data is lost.
- Reset has no asynchronous effect. Before the first rising edge, `out` and `mem` contents are unknown.
- Back-to-back operations: a write or read is accepted on every cycle, with no stall or handshake.

## Test plan
- Reset clear:
  - write 16'hABCD to address 5;
  - assert `rst_n`=1 for one edge, then deassert;
  - read address 5 -> `out`=16'h0000, and `out` also reads 0 immediately after the reset edge.
- Fill and readback:
  - with `we`=1, write `data`=random value Rk to each even address 2k for k=0..31 on consecutive cycles;
  - then set `we`=0 and read 100 random even addresses -> `out` equals the matching Rk one cycle after `addr` is applied.
- Full range:
  - write `data`=addr ^ 16'h5A5A to all 64 addresses;
  - read 63, 0, 1, 62 -> 16'h5A65, 16'h5A5A, 16'h5A5B, 16'h5A64.
- Write-first:
  - `mem[10]`=16'h1111;
  - at one edge set `we`=1, `addr`=10, `data`=16'h2222 -> `out`=16'h2222 after that edge.
- Read latency and hold:
  - set `addr`=3 (`mem[3]`=16'h00FF), then `addr`=4 (`mem[4]`=16'hFF00) on the next edge -> `out` is 16'h00FF for exactly one cycle, then 16'hFF00.
- Reset mid-write:
  - assert reset on the same edge as `we`=1, `addr`=7, `data`=16'h7777 -> `mem[7]` reads 16'h0000 afterwards.

Source files
------------

// File: rtl/dut_ram.sv
// 64 x 16 single-port synchronous RAM with a registered, write-first read port.
// Latency: read and write both take effect at the next rising edge; out is valid one cycle after addr.
// Backpressure: none; one read (and optionally a write) is accepted every cycle.
//
// Ports:
//   clk   - single clock, all state updates on the rising edge
//   rst_n - synchronous reset, asserted HIGH despite the legacy name;
//           clears the whole array and out in one edge
//   we    - write enable, active-high
//   addr  - word address 0..63, shared by read and write
//   data  - write data
//   out   - registered read data
module dut_ram (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [15:0] data,
  output logic [15:0] out
);

  logic [15:0] mem_q [64];
  logic [15:0] mem_d [64];
  logic [15:0] out_q;
  logic [15:0] out_d;

  // Next-state for the non-reset case. A write to the addressed word is
  // forwarded straight to the read register so the same-edge read sees the
  // new data (write-first).
  always_comb begin
    mem_d = mem_q;
    out_d = mem_q[addr];
    if (we) begin
      mem_d[addr] = data;
      out_d       = data;
    end
  end

  // rst_n is active-high: a 1 on the edge wipes every word and the output,
  // discarding any write presented on that same edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem_q <= '{default: 16'h0000};
      out_q <= 16'h0000;
    end else begin
      mem_q <= mem_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_dut_ram.sv
module tb_dut_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [5:0]  addr;
  logic [15:0] data;
  logic [15:0] out;

  dut_ram u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .addr (addr),
    .data (data),
    .out  (out)
  );

  always #5 clk = ~clk;

  int unsigned pass_cnt  = 0;
  int unsigned check_cnt = 0;

  // Behavioural model: plain array of words, updated by the spec's rules.
  logic [15:0] model [64];

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Apply one cycle of stimulus, advance past the edge and return the value
  // the model predicts for out after that edge.
  task automatic cycle(input logic r, input logic w, input logic [5:0] a,
                       input logic [15:0] d, output logic [15:0] exp);
    rst_n = r; we = w; addr = a; data = d;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 64; i++) model[i] = 16'h0000;
      exp = 16'h0000;
    end else if (w) begin
      model[a] = d;
      exp = d;
    end else begin
      exp = model[a];
    end
  endtask

  initial begin
    logic [15:0] e;
    logic [15:0] held;
    logic [15:0] rk [32];
    logic [15:0] fr_exp [4];
    logic [5:0]  fr_addr [4];
    int unsigned k;

    rst_n = 1'b1; we = 1'b0; addr = '0; data = '0;
    for (int i = 0; i < 64; i++) model[i] = 'x;

    // Reset state.
    cycle(1'b1, 1'b0, 6'd0, 16'h0, e);
    check("reset_out", out, 16'h0000);

    // Directed table: reset clear, write-first, read latency, reset mid-write.
    vecs.push_back('{"rc_write5",     0, 1, 6'd5,  16'hABCD, 16'hABCD});
    vecs.push_back('{"rc_reset",      1, 0, 6'd5,  16'h0000, 16'h0000});
    vecs.push_back('{"rc_read5",      0, 0, 6'd5,  16'h0000, 16'h0000});
    vecs.push_back('{"wf_init10",     0, 1, 6'd10, 16'h1111, 16'h1111});
    vecs.push_back('{"wf_read10",     0, 0, 6'd10, 16'h0000, 16'h1111});
    vecs.push_back('{"wf_write10",    0, 1, 6'd10, 16'h2222, 16'h2222});
    vecs.push_back('{"wf_reread10",   0, 0, 6'd10, 16'h0000, 16'h2222});
    vecs.push_back('{"lat_init3",     0, 1, 6'd3,  16'h00FF, 16'h00FF});
    vecs.push_back('{"lat_init4",     0, 1, 6'd4,  16'hFF00, 16'hFF00});
    vecs.push_back('{"lat_read3",     0, 0, 6'd3,  16'h0000, 16'h00FF});
    vecs.push_back('{"lat_read4",     0, 0, 6'd4,  16'h0000, 16'hFF00});
    vecs.push_back('{"rmw_prewrite7", 0, 1, 6'd7,  16'h1234, 16'h1234});
    vecs.push_back('{"rmw_reset7",    1, 1, 6'd7,  16'h7777, 16'h0000});
    vecs.push_back('{"rmw_read7",     0, 0, 6'd7,  16'h0000, 16'h0000});
    vecs.push_back('{"rmw_read10",    0, 0, 6'd10, 16'h0000, 16'h0000});
    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].data, e);
      check(vecs[i].name, out, vecs[i].exp);
    end

    // Latency/hold: out shows mem[3] for exactly one cycle, then mem[4].
    cycle(1'b0, 1'b1, 6'd3, 16'h00FF, e);
    cycle(1'b0, 1'b1, 6'd4, 16'hFF00, e);
    cycle(1'b0, 1'b0, 6'd3, 16'h0, e);
    held = out;
    addr = 6'd4;              // change addr mid-cycle: out must not follow it
    @(negedge clk);
    check("hold_mid_cycle", out, held);
    check("hold_value3", out, 16'h00FF);
    cycle(1'b0, 1'b0, 6'd4, 16'h0, e);
    check("next_value4", out, 16'hFF00);

    // Full range: addr ^ 5A5A everywhere, read back corners.
    for (int a = 0; a < 64; a++) begin
      logic [15:0] v;
      v = 16'(a) ^ 16'h5A5A;
      cycle(1'b0, 1'b1, 6'(a), v, e);
    end
    fr_addr = '{6'd63, 6'd0, 6'd1, 6'd62};
    fr_exp  = '{16'h5A65, 16'h5A5A, 16'h5A5B, 16'h5A64};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, fr_addr[i], 16'h0, e);
      check($sformatf("full_range_a%0d", fr_addr[i]), out, fr_exp[i]);
    end

    // Fill even addresses with random Rk, read back 100 random even addrs.
    for (int i = 0; i < 32; i++) begin
      rk[i] = 16'($urandom);
      cycle(1'b0, 1'b1, 6'(2 * i), rk[i], e);
    end
    for (int n = 0; n < 100; n++) begin
      k = $urandom_range(31);
      cycle(1'b0, 1'b0, 6'(2 * k), 16'($urandom), e);
      check($sformatf("fill_read_a%0d", 2 * k), out, rk[k]);
    end

    // Randomised mixed traffic against the model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic r, w;
      r = ($urandom_range(49) == 0);
      w = $urandom_range(1) == 1;
      cycle(r, w, 6'($urandom), 16'($urandom), e);
      check($sformatf("rand_%0d", n), out, e);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
